// File: rtl/mem_pkg.sv
// Shared types and constants for the mem_responder slice.
package mem_pkg;

    localparam int unsigned WORD_W          = 32;
    localparam int unsigned DEPTH_DEF       = 64;
    localparam int unsigned WAIT_CYCLES_DEF = 2;
    localparam int unsigned CNT_W           = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } state_e;

    typedef struct packed {
        logic              we;
        logic [WORD_W-1:0] addr;
        logic [WORD_W-1:0] wdata;
    } mem_req_t;

    // Rejects misaligned byte addresses and addresses past the last word.
    function automatic logic addr_bad(input logic [WORD_W-1:0] addr, input int unsigned depth);
        return (addr[1:0] != 2'b00) || (addr >= WORD_W'(4 * depth));
    endfunction

endpackage

// File: rtl/mem_array.sv
// DEPTH x WORD_W storage: one synchronous write port, one combinational read port.
module mem_array
    import mem_pkg::*;
#(
    parameter int unsigned DEPTH = DEPTH_DEF,
    parameter int unsigned AW    = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              we_i,
    input  logic [AW-1:0]     waddr_i,
    input  logic [WORD_W-1:0] wdata_i,
    input  logic [AW-1:0]     raddr_i,
    output logic [WORD_W-1:0] rdata_o
);

    // No reset: contents survive a responder reset.
    logic [WORD_W-1:0] mem_q [DEPTH];

    always_ff @(posedge clk) begin
        if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
    end

    assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/mem_responder.sv
// Single-port memory responder with optional wait states.
// Wait-state support is built only when MEM_RESPONDER_WAIT_EN is defined.
module mem_responder
    import mem_pkg::*;
#(
    parameter int unsigned DEPTH       = DEPTH_DEF,
    parameter int unsigned WAIT_CYCLES = WAIT_CYCLES_DEF
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              req,
    input  logic              we,
    input  logic [WORD_W-1:0] addr,
    input  logic [WORD_W-1:0] wdata,
    output logic              ready,
    output logic [WORD_W-1:0] rdata,
    output logic              err,
    output logic              busy
);

    localparam int unsigned AW = $clog2(DEPTH);

    if (WAIT_CYCLES > 15 || DEPTH < 2) begin : g_param_check
        $error("mem_responder: WAIT_CYCLES must be 0..15 and DEPTH at least 2");
    end

    state_e            state_q, state_d;
    mem_req_t          req_q, req_d;
    logic              ready_q, ready_d;
    logic              err_q, err_d;
    logic [WORD_W-1:0] rdata_q, rdata_d;
    logic              busy_q, busy_d;
`ifdef MEM_RESPONDER_WAIT_EN
    logic [CNT_W-1:0]  cnt_q, cnt_d;
`endif

    mem_req_t          acc;
    logic              acc_bad;
    logic              enter_resp;
    logic              mem_we;
    logic [WORD_W-1:0] mem_rdata;

    // With zero wait states the access is served straight from the inputs.
    always_comb begin
        acc.we    = we;
        acc.addr  = addr;
        acc.wdata = wdata;
        if (state_q != IDLE) begin
            acc = req_q;
        end
        acc_bad = addr_bad(acc.addr, DEPTH);
    end

    always_comb begin
        state_d    = state_q;
        req_d      = req_q;
        ready_d    = 1'b0;
        err_d      = 1'b0;
        rdata_d    = '0;
        enter_resp = 1'b0;
`ifdef MEM_RESPONDER_WAIT_EN
        cnt_d      = cnt_q;
`endif
        unique case (state_q)
            IDLE: begin
                if (req) begin
                    req_d.we    = we;
                    req_d.addr  = addr;
                    req_d.wdata = wdata;
`ifdef MEM_RESPONDER_WAIT_EN
                    cnt_d = CNT_W'(WAIT_CYCLES);
                    if (WAIT_CYCLES == 0) begin
                        state_d    = RESP;
                        enter_resp = 1'b1;
                    end else begin
                        state_d = WAIT;
                    end
`else
                    state_d    = RESP;
                    enter_resp = 1'b1;
`endif
                end
            end
`ifdef MEM_RESPONDER_WAIT_EN
            WAIT: begin
                cnt_d = cnt_q - CNT_W'(1);
                if (cnt_q == CNT_W'(1)) begin
                    state_d    = RESP;
                    enter_resp = 1'b1;
                end
            end
`endif
            RESP: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        // Response fields are computed on the edge that enters RESP.
        if (enter_resp) begin
            ready_d = 1'b1;
            err_d   = acc_bad;
            if (!acc_bad) begin
                rdata_d = acc.we ? acc.wdata : mem_rdata;
            end
        end
        busy_d = (state_d != IDLE);
    end

    // A reset coinciding with the RESP entry edge must suppress the commit.
    assign mem_we = enter_resp && acc.we && !acc_bad && reset;

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q <= IDLE;
            req_q   <= '0;
            ready_q <= 1'b0;
            err_q   <= 1'b0;
            rdata_q <= '0;
            busy_q  <= 1'b0;
`ifdef MEM_RESPONDER_WAIT_EN
            cnt_q   <= '0;
`endif
        end else begin
            state_q <= state_d;
            req_q   <= req_d;
            ready_q <= ready_d;
            err_q   <= err_d;
            rdata_q <= rdata_d;
            busy_q  <= busy_d;
`ifdef MEM_RESPONDER_WAIT_EN
            cnt_q   <= cnt_d;
`endif
        end
    end

    mem_array #(
        .DEPTH (DEPTH),
        .AW    (AW)
    ) u_mem_array (
        .clk     (clk),
        .we_i    (mem_we),
        .waddr_i (acc.addr[AW+1:2]),
        .wdata_i (acc.wdata),
        .raddr_i (acc.addr[AW+1:2]),
        .rdata_o (mem_rdata)
    );

    assign ready = ready_q;
    assign err   = err_q;
    assign rdata = rdata_q;
    assign busy  = busy_q;

endmodule

// File: tb/tb_mem_responder.sv
// Scoreboard bench for mem_responder: driver queues expected responses, monitor checks each ready pulse.
module tb_mem_responder;

    localparam int unsigned DEPTH = 64;
    localparam int unsigned WAITC = 2;
`ifdef MEM_RESPONDER_WAIT_EN
    localparam int LAT = WAITC + 1;
`else
    localparam int LAT = 1;
`endif

    typedef struct {
        logic        err;
        logic [31:0] rdata;
        int          acc;
        bit          chk_lat;
    } exp_t;

    logic        clk;
    logic        reset;
    logic        req;
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        ready;
    logic [31:0] rdata;
    logic        err;
    logic        busy;

    exp_t exp_q[$];
    exp_t mon_e;
    int   n_chk    = 0;
    int   n_fail   = 0;
    int   n_ready  = 0;
    int   n_acc    = 0;
    int   cyc      = 0;
    int   last_rdy = 0;
    int   prev_rdy = 0;
    bit   mon_en   = 1'b0;

    mem_responder #(
        .DEPTH       (DEPTH),
        .WAIT_CYCLES (WAITC)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .req   (req),
        .we    (we),
        .addr  (addr),
        .wdata (wdata),
        .ready (ready),
        .rdata (rdata),
        .err   (err),
        .busy  (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: actual=0x%08h required=0x%08h (edge %0d)", name, act, exp, cyc);
        end
    endtask

    // Monitor: every ready pulse must match the oldest queued expectation.
    always @(negedge clk) begin
        if (mon_en && reset === 1'b1) begin
            if (ready === 1'b1) begin
                n_ready++;
                prev_rdy = last_rdy;
                last_rdy = cyc;
                if (exp_q.size() == 0) begin
                    n_chk++;
                    n_fail++;
                    $display("FAIL unexpected_ready: actual=1 required=0 (edge %0d)", cyc);
                end else begin
                    mon_e = exp_q.pop_front();
                    check("resp_err", 32'(err), 32'(mon_e.err));
                    check("resp_rdata", rdata, mon_e.rdata);
                    if (mon_e.chk_lat) begin
                        check("resp_latency", 32'(cyc - mon_e.acc + 1), 32'(LAT));
                    end
                end
            end else begin
                check("idle_err", 32'(err), 32'd0);
                check("idle_rdata", rdata, 32'd0);
            end
        end
    end

    task automatic wait_ready(input int target);
        int k = 0;
        #1;
        while (n_ready < target && k < 40) begin
            @(negedge clk);
            #1;
            k++;
        end
        if (n_ready < target) begin
            n_chk++;
            n_fail++;
            $display("FAIL ready_timeout: actual=%0d required=%0d", n_ready, target);
        end
    endtask

    task automatic issue(input logic w, input logic [31:0] a, input logic [31:0] d,
                         input logic e_err, input logic [31:0] e_rd, input bit pulse);
        exp_t e;
        @(negedge clk);
        e.err     = e_err;
        e.rdata   = e_rd;
        e.acc     = cyc + 1;
        e.chk_lat = 1'b1;
        exp_q.push_back(e);
        n_acc++;
        req   = 1'b1;
        we    = w;
        addr  = a;
        wdata = d;
        @(negedge clk);
        req = pulse;
        #1 check("busy_after_accept", 32'(busy), 32'd1);
        @(negedge clk);
        req = 1'b0;
        wait_ready(n_acc);
        @(negedge clk);
        #1 check("busy_idle", 32'(busy), 32'd0);
    endtask

    task automatic check_reset_outputs();
        check("rst_ready", 32'(ready), 32'd0);
        check("rst_err", 32'(err), 32'd0);
        check("rst_rdata", rdata, 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int rdy_before;
        reset = 1'b0;
        req   = 1'b0;
        we    = 1'b0;
        addr  = '0;
        wdata = '0;
        repeat (3) @(negedge clk);
        #1 check_reset_outputs();
        reset  = 1'b1;
        mon_en = 1'b1;

        issue(1'b1, 32'd80,          32'h0000_1111, 1'b0, 32'h0000_1111, 1'b0);
        issue(1'b1, 32'd84,          32'd7,         1'b0, 32'd7,         1'b0);
        issue(1'b0, 32'd84,          32'd0,         1'b0, 32'd7,         1'b0);
        issue(1'b1, 32'h53,          32'd5,         1'b1, 32'd0,         1'b0);
        issue(1'b0, 32'h50,          32'd0,         1'b0, 32'h0000_1111, 1'b0);
        issue(1'b0, 32'd256,         32'd0,         1'b1, 32'd0,         1'b0);
        issue(1'b1, 32'd252,         32'hDEAD_BEEF, 1'b0, 32'hDEAD_BEEF, 1'b0);
        issue(1'b0, 32'd252,         32'd0,         1'b0, 32'hDEAD_BEEF, 1'b0);
        issue(1'b1, 32'h1000_0054,   32'h55,        1'b1, 32'd0,         1'b0);
        issue(1'b0, 32'd84,          32'd0,         1'b0, 32'd7,         1'b0);
        issue(1'b1, 32'd0,           32'hA5A5_A5A5, 1'b0, 32'hA5A5_A5A5, 1'b0);
        issue(1'b0, 32'd0,           32'd0,         1'b0, 32'hA5A5_A5A5, 1'b0);

        // Abort: reset lands after acceptance (in WAIT, then on the RESP entry edge).
        rdy_before = n_ready;
`ifdef MEM_RESPONDER_WAIT_EN
        for (int dly = 0; dly < 2; dly++) begin
            @(negedge clk);
            req   = 1'b1;
            we    = 1'b1;
            addr  = 32'd80;
            wdata = 32'd9 + 32'(dly);
            @(negedge clk);
            req = 1'b0;
            repeat (dly) @(negedge clk);
            reset = 1'b0;
            @(negedge clk);
            #1 check_reset_outputs();
            @(negedge clk);
            reset = 1'b1;
            @(negedge clk);
        end
`else
        @(negedge clk);
        req   = 1'b1;
        we    = 1'b1;
        addr  = 32'd80;
        wdata = 32'd9;
        reset = 1'b0;
        @(negedge clk);
        req = 1'b0;
        #1 check_reset_outputs();
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
`endif
        repeat (4) @(negedge clk);
        #1 check("abort_no_ready", 32'(n_ready), 32'(rdy_before));
        issue(1'b0, 32'd80, 32'd0, 1'b0, 32'h0000_1111, 1'b0);

        // A req pulse while the access is in flight must not start another access.
        issue(1'b0, 32'd84, 32'd0, 1'b0, 32'd7, 1'b1);
        repeat (3) @(negedge clk);
        #1 check("pulse_single_ready", 32'(n_ready), 32'(n_acc));

        // Held req: second access accepted after one idle cycle.
        @(negedge clk);
        for (int i = 0; i < 2; i++) begin
            exp_t e;
            e.err     = 1'b0;
            e.rdata   = 32'd7;
            e.acc     = 0;
            e.chk_lat = 1'b0;
            exp_q.push_back(e);
        end
        n_acc += 2;
        req  = 1'b1;
        we   = 1'b0;
        addr = 32'd84;
        wait_ready(n_acc);
        req = 1'b0;
        check("held_req_spacing", 32'(last_rdy - prev_rdy), 32'(LAT + 1));
        repeat (4) @(negedge clk);

        #1;
        check("ready_count", 32'(n_ready), 32'(n_acc));
        check("queue_empty", 32'(exp_q.size()), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
